wb_writeback_seq: RTL and testbench
===================================

# wb_writeback_seq

Writeback-stage sequencer on the consumer side of the MEM/WB pipeline register. It takes the registered writeback bundle and turns it into write-port transactions:
- single-cycle writes to the scalar register file;
- single-cycle 128-bit writes to the matrix register file;
- a 4-cycle burst that spreads one 128-bit matrix result across four consecutive scalar registers, stalling the pipeline while the burst runs.

## Interface
Parameters:
- XLEN, 32, scalar data width
- MLEN, 128, matrix result width; MLEN/XLEN = NW = 4 words
- REG_AW, 5, scalar register address width
- MREG_AW, 3, matrix register address width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- wb_mem_data  in  XLEN  load data from MEM/WB
- wb_alu_o  in  XLEN  ALU result from MEM/WB
- wb_matrix_o  in  MLEN  matrix result from MEM/WB
- wb_rd  in  REG_AW  destination register
- wb_mem2reg  in  1  1 = scalar write data is wb_mem_data, 0 = wb_alu_o
- wb_w_select  in  2  writeback kind (encoding below)
- rf_we  out  1  scalar register file write enable
- rf_waddr  out  REG_AW  scalar write address
- rf_wdata  out  XLEN  scalar write data
- mrf_we  out  1  matrix register file write enable
- mrf_waddr  out  MREG_AW  matrix write address
- mrf_wdata  out  MLEN  matrix write data
- wb_stall  out  1  pipeline control must hold MEM/WB and all earlier stages while high

## Operation
wb_w_select encoding:
- 00 = NONE
- 01 = SCALAR
- 10 = MSPLIT
- 11 = MREG

States:
- IDLE: inputs are decoded in the same cycle; all write outputs are combinational from the inputs.
  - NONE: no enables asserted, wb_stall=0.
  - SCALAR: rf_we=1, rf_waddr=wb_rd, rf_wdata = wb_mem2reg ? wb_mem_data : wb_alu_o. wb_stall=0.
  - MREG: mrf_we=1, mrf_waddr=wb_rd[MREG_AW-1:0], mrf_wdata=wb_matrix_o. wb_stall=0. wb_mem2reg is ignored.
  - MSPLIT: write word 0 (wb_matrix_o[31:0]) to wb_rd and assert wb_stall=1. Capture wb_matrix_o[127:32] and wb_rd into internal registers, set idx=1, go to BURST.
- BURST: all inputs are ignored; MEM/WB is being held and still presents the same instruction.
  - Drive rf_we=1, rf_waddr = captured_rd + idx (mod 32, 5-bit wrap), rf_wdata = captured word idx (word i = bits [32i+31:32i]).
  - wb_stall=1 while idx<3; wb_stall=0 when idx==3.
  - idx increments each cycle. After idx==3, go to IDLE.
- x0 rule: any scalar write whose address is 0 has rf_we forced to 0, including individual burst words. Stall timing is unaffected.
- mrf_we is never asserted in BURST. rf_we and mrf_we are never high together.

## Timing
- Scalar and matrix-register writes: zero latency, committed at the same posedge the MEM/WB values are presented.
- MSPLIT: 4 cycles per instruction (T0..T3), wb_stall high in T0..T2 and low in T3. MEM/WB loads the next instruction at the T3 edge; it is seen in IDLE at T4.
- Back-to-back MSPLIT: the second instruction starts at T4 with no bubble.
- Reset:
  - While rst=0, all outputs are 0, state=IDLE, idx=0, and captured registers are cleared.
  - Reset asserted mid-burst aborts the burst; remaining words are dropped.
  - The first cycle after reset release decodes inputs normally.
- Address wrap: rd=30 gives burst writes to 30, 31, 0 (suppressed), 1.

## Structure
- Shared package riscv_wb_pkg holds:
  - WSEL_NONE, WSEL_SCALAR, WSEL_MSPLIT, WSEL_MREG;
  - XLEN, MLEN, NW, REG_AW, MREG_AW;
  - the state enum {ST_IDLE, ST_BURST}.
- Single module; no sub-module. The burst counter and data capture are small enough to live inline.

## Test plan
- SCALAR, rd=5, mem2reg=1, mem_data=0xDEADBEEF, alu_o=0x1 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, wb_stall=0; repeat with mem2reg=0 -> rf_wdata=0x1.
- MREG, rd=0x1B, matrix=0x0011…FF -> mrf_we=1, mrf_waddr=3, mrf_wdata equals input, rf_we=0, wb_stall=0.
- MSPLIT, rd=8, matrix=0x44444444_33333333_22222222_11111111 -> cycles T0..T3 write 0x11111111@8, 0x22222222@9, 0x33333333@10, 0x44444444@11. wb_stall=1,1,1,0. Inputs changed during T1..T3 have no effect.
- MSPLIT, rd=30 -> writes @30, @31, then rf_we=0 at address 0, then @1 with word 3. Stall pattern unchanged.
- Two MSPLIT back-to-back, then SCALAR -> 8 consecutive burst writes, SCALAR write at T8. Also: rst=0 asserted at T2 of a burst -> all outputs 0 next cycle; after release, new SCALAR input is written immediately, with no residual burst words.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// Shared writeback-stage definitions: select encoding, datapath widths and
// the sequencer state type.
package riscv_wb_pkg;

  localparam int XLEN    = 32;
  localparam int MLEN    = 128;
  localparam int NW      = MLEN / XLEN;
  localparam int REG_AW  = 5;
  localparam int MREG_AW = 3;

  localparam logic [1:0] WSEL_NONE   = 2'b00;
  localparam logic [1:0] WSEL_SCALAR = 2'b01;
  localparam logic [1:0] WSEL_MSPLIT = 2'b10;
  localparam logic [1:0] WSEL_MREG   = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_writeback_seq.sv
// Writeback sequencer: turns the MEM/WB bundle into scalar / matrix register
// file writes, spreading a matrix result over NW scalar registers when asked.
module wb_writeback_seq #(
  parameter int XLEN    = riscv_wb_pkg::XLEN,
  parameter int MLEN    = riscv_wb_pkg::MLEN,
  parameter int REG_AW  = riscv_wb_pkg::REG_AW,
  parameter int MREG_AW = riscv_wb_pkg::MREG_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    wb_mem_data,
  input  logic [XLEN-1:0]    wb_alu_o,
  input  logic [MLEN-1:0]    wb_matrix_o,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic               wb_mem2reg,
  input  logic [1:0]         wb_w_select,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               mrf_we,
  output logic [MREG_AW-1:0] mrf_waddr,
  output logic [MLEN-1:0]    mrf_wdata,
  output logic               wb_stall
);
  import riscv_wb_pkg::*;

  localparam int NW_L  = MLEN / XLEN;
  localparam int IDX_W = $clog2(NW_L);
  localparam int CAP_W = MLEN - XLEN;

  wb_state_e          state;
  logic [IDX_W-1:0]   idx;
  logic [REG_AW-1:0]  cap_rd;
  logic [CAP_W-1:0]   cap_words;
  logic [REG_AW-1:0]  burst_addr;
  logic               burst_last;

  // Captured words shift down each burst cycle, so the current word is always
  // the low XLEN bits.
  assign burst_addr = cap_rd + REG_AW'(idx);
  assign burst_last = (idx == IDX_W'(NW_L - 1));

  always_comb begin
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    mrf_we    = 1'b0;
    mrf_waddr = '0;
    mrf_wdata = '0;
    wb_stall  = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          case (wb_w_select)
            WSEL_SCALAR: begin
              rf_we    = (wb_rd != '0);
              rf_waddr = wb_rd;
              rf_wdata = wb_mem2reg ? wb_mem_data : wb_alu_o;
            end
            WSEL_MREG: begin
              mrf_we    = 1'b1;
              mrf_waddr = wb_rd[MREG_AW-1:0];
              mrf_wdata = wb_matrix_o;
            end
            WSEL_MSPLIT: begin
              rf_we    = (wb_rd != '0);
              rf_waddr = wb_rd;
              rf_wdata = wb_matrix_o[XLEN-1:0];
              wb_stall = 1'b1;
            end
            default: ;
          endcase
        end
        ST_BURST: begin
          rf_we    = (burst_addr != '0);
          rf_waddr = burst_addr;
          rf_wdata = cap_words[XLEN-1:0];
          wb_stall = !burst_last;
        end
        default: ;
      endcase
    end
  end

  // ---- burst sequencing state ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cap_rd    <= '0;
      cap_words <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wb_w_select == WSEL_MSPLIT) begin
            state     <= ST_BURST;
            idx       <= IDX_W'(1);
            cap_rd    <= wb_rd;
            cap_words <= wb_matrix_o[MLEN-1:XLEN];
          end
        end
        ST_BURST: begin
          cap_words <= cap_words >> XLEN;
          if (burst_last) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_writeback_seq.sv
// Scoreboard bench for wb_writeback_seq: directed vectors push expected
// per-cycle outputs; a negedge monitor pops and compares.
module tb_wb_writeback_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  wb_mem_data;
  logic [31:0]  wb_alu_o;
  logic [127:0] wb_matrix_o;
  logic [4:0]   wb_rd;
  logic         wb_mem2reg;
  logic [1:0]   wb_w_select;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic         mrf_we;
  logic [2:0]   mrf_waddr;
  logic [127:0] mrf_wdata;
  logic         wb_stall;

  always #5 clk = ~clk;

  wb_writeback_seq dut (
    .clk(clk), .rst(rst),
    .wb_mem_data(wb_mem_data), .wb_alu_o(wb_alu_o), .wb_matrix_o(wb_matrix_o),
    .wb_rd(wb_rd), .wb_mem2reg(wb_mem2reg), .wb_w_select(wb_w_select),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mrf_we(mrf_we), .mrf_waddr(mrf_waddr), .mrf_wdata(mrf_wdata),
    .wb_stall(wb_stall)
  );

  typedef struct {
    string        name;
    logic         full;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         mrf_we;
    logic [2:0]   mrf_waddr;
    logic [127:0] mrf_wdata;
    logic         stall;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [127:0] M_SPLIT = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] M_REG   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] M_A     = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [127:0] M_B     = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] M_JUNK  = 128'hDEADDEAD_BEEFBEEF_CAFECAFE_F00DF00D;

  function automatic exp_t e_rf(string n, logic we, logic [4:0] a, logic [31:0] d, logic st);
    exp_t e;
    e.name = n; e.full = 1'b0;
    e.rf_we = we; e.rf_waddr = a; e.rf_wdata = d;
    e.mrf_we = 1'b0; e.mrf_waddr = '0; e.mrf_wdata = '0;
    e.stall = st;
    return e;
  endfunction

  function automatic exp_t e_mrf(string n, logic [2:0] a, logic [127:0] d);
    exp_t e;
    e = e_rf(n, 1'b0, '0, '0, 1'b0);
    e.mrf_we = 1'b1; e.mrf_waddr = a; e.mrf_wdata = d;
    return e;
  endfunction

  function automatic exp_t e_zero(string n, logic full);
    exp_t e;
    e = e_rf(n, 1'b0, '0, '0, 1'b0);
    e.full = full;
    return e;
  endfunction

  // One cycle: drive inputs, push the expectation, advance past the edge.
  task automatic step(input logic r, input logic [1:0] ws, input logic [4:0] rd,
                      input logic m2r, input logic [31:0] md, input logic [31:0] alu,
                      input logic [127:0] mat, input exp_t e);
    rst = r; wb_w_select = ws; wb_rd = rd; wb_mem2reg = m2r;
    wb_mem_data = md; wb_alu_o = alu; wb_matrix_o = mat;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ok = (rf_we === e.rf_we) && (mrf_we === e.mrf_we) && (wb_stall === e.stall);
        if (e.rf_we || e.full)
          ok = ok && (rf_waddr === e.rf_waddr) && (rf_wdata === e.rf_wdata);
        if (e.mrf_we || e.full)
          ok = ok && (mrf_waddr === e.mrf_waddr) && (mrf_wdata === e.mrf_wdata);
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL %s: got we=%0d wa=%0d wd=%h mwe=%0d mwa=%0d mwd=%h stall=%0d; want we=%0d wa=%0d wd=%h mwe=%0d mwa=%0d mwd=%h stall=%0d",
                   e.name, rf_we, rf_waddr, rf_wdata, mrf_we, mrf_waddr, mrf_wdata, wb_stall,
                   e.rf_we, e.rf_waddr, e.rf_wdata, e.mrf_we, e.mrf_waddr, e.mrf_wdata, e.stall);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; wb_w_select = 2'b00; wb_rd = '0; wb_mem2reg = 1'b0;
    wb_mem_data = '0; wb_alu_o = '0; wb_matrix_o = '0;
    @(posedge clk); #1;

    step(1'b0, 2'b01, 5'd5, 1'b1, 32'hDEADBEEF, 32'h1, M_REG, e_zero("reset_scalar", 1'b1));
    step(1'b0, 2'b10, 5'd8, 1'b0, 32'h0, 32'h0, M_SPLIT, e_zero("reset_msplit", 1'b1));

    step(1'b1, 2'b01, 5'd5, 1'b1, 32'hDEADBEEF, 32'h1, '0, e_rf("scalar_mem", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0));
    step(1'b1, 2'b01, 5'd5, 1'b0, 32'hDEADBEEF, 32'h1, '0, e_rf("scalar_alu", 1'b1, 5'd5, 32'h1, 1'b0));
    step(1'b1, 2'b11, 5'h1B, 1'b1, 32'h0, 32'h0, M_REG, e_mrf("mreg", 3'd3, M_REG));
    step(1'b1, 2'b01, 5'd0, 1'b0, 32'h0, 32'h55, '0, e_rf("scalar_x0", 1'b0, 5'd0, 32'h0, 1'b0));
    step(1'b1, 2'b00, 5'd7, 1'b0, 32'h9, 32'h9, M_REG, e_zero("none", 1'b0));

    step(1'b1, 2'b10, 5'd8, 1'b0, 32'h0, 32'h0, M_SPLIT, e_rf("split8_t0", 1'b1, 5'd8, 32'h11111111, 1'b1));
    step(1'b1, 2'b01, 5'd3, 1'b1, 32'hFFFF, 32'hEEEE, M_JUNK, e_rf("split8_t1", 1'b1, 5'd9, 32'h22222222, 1'b1));
    step(1'b1, 2'b11, 5'd2, 1'b0, 32'h0, 32'h0, M_JUNK, e_rf("split8_t2", 1'b1, 5'd10, 32'h33333333, 1'b1));
    step(1'b1, 2'b10, 5'd0, 1'b0, 32'h0, 32'h0, M_JUNK, e_rf("split8_t3", 1'b1, 5'd11, 32'h44444444, 1'b0));
    step(1'b1, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, '0, e_zero("after_split8", 1'b0));

    step(1'b1, 2'b10, 5'd30, 1'b0, 32'h0, 32'h0, M_SPLIT, e_rf("wrap_t0", 1'b1, 5'd30, 32'h11111111, 1'b1));
    step(1'b1, 2'b10, 5'd30, 1'b0, 32'h0, 32'h0, M_SPLIT, e_rf("wrap_t1", 1'b1, 5'd31, 32'h22222222, 1'b1));
    step(1'b1, 2'b10, 5'd30, 1'b0, 32'h0, 32'h0, M_SPLIT, e_rf("wrap_t2_x0", 1'b0, 5'd0, 32'h0, 1'b1));
    step(1'b1, 2'b10, 5'd30, 1'b0, 32'h0, 32'h0, M_SPLIT, e_rf("wrap_t3", 1'b1, 5'd1, 32'h44444444, 1'b0));

    step(1'b1, 2'b10, 5'd4, 1'b0, 32'h0, 32'h0, M_A, e_rf("b2b_a0", 1'b1, 5'd4, 32'hA0A0A0A0, 1'b1));
    step(1'b1, 2'b10, 5'd4, 1'b0, 32'h0, 32'h0, M_A, e_rf("b2b_a1", 1'b1, 5'd5, 32'hA1A1A1A1, 1'b1));
    step(1'b1, 2'b10, 5'd4, 1'b0, 32'h0, 32'h0, M_A, e_rf("b2b_a2", 1'b1, 5'd6, 32'hA2A2A2A2, 1'b1));
    step(1'b1, 2'b10, 5'd4, 1'b0, 32'h0, 32'h0, M_A, e_rf("b2b_a3", 1'b1, 5'd7, 32'hA3A3A3A3, 1'b0));
    step(1'b1, 2'b10, 5'd16, 1'b0, 32'h0, 32'h0, M_B, e_rf("b2b_b0", 1'b1, 5'd16, 32'hB0B0B0B0, 1'b1));
    step(1'b1, 2'b10, 5'd16, 1'b0, 32'h0, 32'h0, M_B, e_rf("b2b_b1", 1'b1, 5'd17, 32'hB1B1B1B1, 1'b1));
    step(1'b1, 2'b10, 5'd16, 1'b0, 32'h0, 32'h0, M_B, e_rf("b2b_b2", 1'b1, 5'd18, 32'hB2B2B2B2, 1'b1));
    step(1'b1, 2'b10, 5'd16, 1'b0, 32'h0, 32'h0, M_B, e_rf("b2b_b3", 1'b1, 5'd19, 32'hB3B3B3B3, 1'b0));
    step(1'b1, 2'b01, 5'd7, 1'b0, 32'h0, 32'h12345678, '0, e_rf("b2b_scalar", 1'b1, 5'd7, 32'h12345678, 1'b0));

    step(1'b1, 2'b10, 5'd8, 1'b0, 32'h0, 32'h0, M_SPLIT, e_rf("abort_t0", 1'b1, 5'd8, 32'h11111111, 1'b1));
    step(1'b1, 2'b10, 5'd8, 1'b0, 32'h0, 32'h0, M_SPLIT, e_rf("abort_t1", 1'b1, 5'd9, 32'h22222222, 1'b1));
    step(1'b0, 2'b10, 5'd8, 1'b0, 32'h0, 32'h0, M_SPLIT, e_zero("abort_rst_t2", 1'b1));
    step(1'b0, 2'b01, 5'd9, 1'b0, 32'h0, 32'h0, M_SPLIT, e_zero("abort_rst_t3", 1'b1));
    step(1'b1, 2'b01, 5'd9, 1'b1, 32'hCAFEF00D, 32'h0, '0, e_rf("post_rst_scalar", 1'b1, 5'd9, 32'hCAFEF00D, 1'b0));
    step(1'b1, 2'b00, 5'd9, 1'b0, 32'h0, 32'h0, '0, e_zero("post_rst_idle", 1'b0));

    @(posedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
